// File: rtl/retire_commit_unit.sv
// Retire/commit stage: pops the ROB head, writes the architectural RF,
// frees rename tags, commits stores and drives front-end flush/redirect.
//
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_ret_*             ROB head (valid, ready, tag, rd, data, pc, type,
//                       branch taken, store data)
//   i_st_commit_ack     memory accepted the outstanding store
//   o_retire_ack        pop ROB head (combinational, commit cycle)
//   o_rf_wen/waddr/wdata  RF write port (combinational, commit cycle)
//   o_tag_free_en/free  tag return (combinational, commit cycle)
//   o_st_commit_req/data  store request (registered)
//   o_flush, o_redirect_pc  front-end flush and target (registered)
//   o_st_timeout        sticky store-ack watchdog error
//   o_retired_count     committed instruction count (wraps)

package retire_pkg;
    typedef enum logic [2:0] {
        DT_INT,
        DT_MULT,
        DT_DIV,
        DT_LOAD,
        DT_STORE,
        DT_BRANCH,
        DT_CSR,
        DT_NOP
    } dispatch_type;
endpackage

module retire_commit_unit
    import retire_pkg::*;
#(
    parameter int TAG_W        = 6,
    parameter int REG_W        = 5,
    parameter int DATA_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int ACK_TIMEOUT  = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ret_valid,
    input  logic              i_ret_spec_valid,
    input  logic [TAG_W-1:0]  i_ret_rd_tag,
    input  logic [REG_W-1:0]  i_ret_rd_reg,
    input  logic [DATA_W-1:0] i_ret_data,
    input  logic [DATA_W-1:0] i_ret_pc,
    input  dispatch_type      i_ret_instr_type,
    input  logic              i_ret_branch_taken,
    input  logic [DATA_W-1:0] i_ret_store_data,
    input  logic              i_st_commit_ack,
    output logic              o_retire_ack,
    output logic              o_rf_wen,
    output logic [REG_W-1:0]  o_rf_waddr,
    output logic [DATA_W-1:0] o_rf_wdata,
    output logic              o_tag_free_en,
    output logic [TAG_W-1:0]  o_tag_free,
    output logic              o_st_commit_req,
    output logic [DATA_W-1:0] o_st_commit_data,
    output logic              o_flush,
    output logic [DATA_W-1:0] o_redirect_pc,
    output logic              o_st_timeout,
    output logic [15:0]       o_retired_count
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int WD_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(ACK_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ST_WAIT,
        S_FLUSH
    } state_t;

    state_t          state;
    logic [FC_W-1:0] flush_cnt;
    logic [WD_W-1:0] wd_cnt;

    logic head_rdy;
    logic is_alu;
    logic is_br;
    logic is_st;
    logic idle_rdy;
    logic commit_alu;
    logic commit_br;
    logic st_done;

    assign head_rdy = i_ret_valid & i_ret_spec_valid;
    assign idle_rdy = (state == S_IDLE) & head_rdy;

    assign is_alu = i_ret_instr_type inside {DT_INT, DT_MULT, DT_DIV, DT_LOAD};
    assign is_br  = (i_ret_instr_type == DT_BRANCH);
    assign is_st  = (i_ret_instr_type == DT_STORE);

    assign commit_alu = idle_rdy & is_alu;
    assign commit_br  = idle_rdy & is_br;
    // The store's head entry is popped only once memory has accepted it.
    assign st_done    = (state == S_ST_WAIT) & i_st_commit_ack;

    assign o_retire_ack  = commit_alu | commit_br | st_done;
    assign o_tag_free_en = o_retire_ack;
    assign o_tag_free    = o_retire_ack ? i_ret_rd_tag : '0;

    // x0 is hardwired; its commit frees the tag but never writes the RF.
    assign o_rf_wen   = commit_alu & (i_ret_rd_reg != '0);
    assign o_rf_waddr = commit_alu ? i_ret_rd_reg : '0;
    assign o_rf_wdata = commit_alu ? i_ret_data : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= S_IDLE;
            flush_cnt        <= '0;
            wd_cnt           <= '0;
            o_st_commit_req  <= 1'b0;
            o_st_commit_data <= '0;
            o_flush          <= 1'b0;
            o_redirect_pc    <= '0;
            o_st_timeout     <= 1'b0;
            o_retired_count  <= '0;
        end else begin
            if (o_retire_ack) begin
                o_retired_count <= o_retired_count + 16'd1;
            end
            unique case (state)
                S_IDLE: begin
                    if (idle_rdy && is_br && i_ret_branch_taken) begin
                        o_flush       <= 1'b1;
                        o_redirect_pc <= i_ret_pc;
                        flush_cnt     <= FC_LOAD;
                        state         <= S_FLUSH;
                    end else if (idle_rdy && is_st) begin
                        o_st_commit_req  <= 1'b1;
                        o_st_commit_data <= i_ret_store_data;
                        wd_cnt           <= '0;
                        state            <= S_ST_WAIT;
                    end
                end
                S_ST_WAIT: begin
                    if (i_st_commit_ack) begin
                        o_st_commit_req <= 1'b0;
                        state           <= S_IDLE;
                    end else begin
                        // Saturate so the counter never wraps while stuck.
                        if (wd_cnt != WD_MAX) begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                        if (wd_cnt == WD_LAST) begin
                            o_st_timeout <= 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt == '0) begin
                        o_flush <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_retire_commit_unit.sv
// Self-checking bench for retire_commit_unit: scoreboard of expected
// retirements plus per-scenario inline checks.
module tb_retire_commit_unit;
    import retire_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ret_valid;
    logic        ret_spec_valid;
    logic [5:0]  ret_rd_tag;
    logic [4:0]  ret_rd_reg;
    logic [31:0] ret_data;
    logic [31:0] ret_pc;
    dispatch_type ret_type;
    logic        ret_taken;
    logic [31:0] ret_sdata;
    logic        st_ack;
    logic        retire_ack;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        tag_free_en;
    logic [5:0]  tag_free;
    logic        st_req;
    logic [31:0] st_data;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        st_timeout;
    logic [15:0] retired_count;

    typedef struct packed {
        logic [5:0]  tag;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    bit   sb_en;
    int   checks;
    int   errors;

    retire_commit_unit #(
        .TAG_W(6), .REG_W(5), .DATA_W(32),
        .FLUSH_CYCLES(2), .ACK_TIMEOUT(4)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_ret_valid(ret_valid),
        .i_ret_spec_valid(ret_spec_valid),
        .i_ret_rd_tag(ret_rd_tag),
        .i_ret_rd_reg(ret_rd_reg),
        .i_ret_data(ret_data),
        .i_ret_pc(ret_pc),
        .i_ret_instr_type(ret_type),
        .i_ret_branch_taken(ret_taken),
        .i_ret_store_data(ret_sdata),
        .i_st_commit_ack(st_ack),
        .o_retire_ack(retire_ack),
        .o_rf_wen(rf_wen),
        .o_rf_waddr(rf_waddr),
        .o_rf_wdata(rf_wdata),
        .o_tag_free_en(tag_free_en),
        .o_tag_free(tag_free),
        .o_st_commit_req(st_req),
        .o_st_commit_data(st_data),
        .o_flush(flush),
        .o_redirect_pc(redirect_pc),
        .o_st_timeout(st_timeout),
        .o_retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every retire ack must match the oldest expected entry.
    always @(negedge clk) begin
        if (sb_en && retire_ack) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_ack got tag %0d exp none", tag_free);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (tag_free !== e.tag || rf_wen !== e.wen || !tag_free_en ||
                    (e.wen && (rf_waddr !== e.waddr || rf_wdata !== e.wdata))) begin
                    errors++;
                    $display("FAIL sb_retire got tag %0d wen %0b a %0d d %h exp tag %0d wen %0b a %0d d %h",
                             tag_free, rf_wen, rf_waddr, rf_wdata,
                             e.tag, e.wen, e.waddr, e.wdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input logic v, input logic s, input logic [5:0] tag,
                        input logic [4:0] rd, input logic [31:0] data,
                        input logic [31:0] pc, input dispatch_type ty,
                        input logic tk, input logic [31:0] sd);
        ret_valid      = v;
        ret_spec_valid = s;
        ret_rd_tag     = tag;
        ret_rd_reg     = rd;
        ret_data       = data;
        ret_pc         = pc;
        ret_type       = ty;
        ret_taken      = tk;
        ret_sdata      = sd;
    endtask

    task automatic clear_head();
        head(0, 0, 0, 0, 0, 0, DT_NOP, 0, 0);
    endtask

    task automatic push(input logic [5:0] tag, input logic wen,
                        input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.tag = tag; e.wen = wen; e.waddr = a; e.wdata = d;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        st_ack = 1'b0;
        clear_head();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({retire_ack, st_req, flush, st_timeout} !== 4'b0 ||
            redirect_pc !== 32'h0 || retired_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_state got ack%0b req%0b fl%0b to%0b pc %h cnt %0d exp all 0",
                     retire_ack, st_req, flush, st_timeout, redirect_pc, retired_count);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_int_commit();
        tick();
        head(1, 1, 6'd5, 5'd3, 32'hDEADBEEF, 32'h0, DT_INT, 0, 0);
        push(6'd5, 1, 5'd3, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if (retire_ack !== 1'b1 || rf_wen !== 1'b1 || tag_free !== 6'd5) begin
            errors++;
            $display("FAIL int_commit got ack %0b wen %0b tag %0d exp 1 1 5",
                     retire_ack, rf_wen, tag_free);
        end
        tick();
        clear_head();
        @(negedge clk);
        checks++;
        if (retired_count !== 16'd1) begin
            errors++;
            $display("FAIL int_count got %0d exp 1", retired_count);
        end
    endtask

    task automatic test_x0_notready();
        tick();
        head(1, 1, 6'd7, 5'd0, 32'h1111, 32'h0, DT_MULT, 0, 0);
        push(6'd7, 0, 5'd0, 32'h0);
        @(negedge clk);
        checks++;
        if (retire_ack !== 1'b1 || rf_wen !== 1'b0 || tag_free !== 6'd7) begin
            errors++;
            $display("FAIL x0_commit got ack %0b wen %0b tag %0d exp 1 0 7",
                     retire_ack, rf_wen, tag_free);
        end
        tick();
        head(1, 0, 6'd8, 5'd4, 32'h2222, 32'h0, DT_INT, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (retire_ack !== 1'b0) begin
                errors++;
                $display("FAIL notready_ack cycle %0d got %0b exp 0", i, retire_ack);
            end
            tick();
        end
        head(1, 1, 6'd8, 5'd4, 32'h2222, 32'h0, DT_CSR, 0, 0);
        @(negedge clk);
        checks++;
        if (retire_ack !== 1'b0 || st_req !== 1'b0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL other_type got ack %0b req %0b fl %0b exp 0 0 0",
                     retire_ack, st_req, flush);
        end
        tick();
        clear_head();
        @(negedge clk);
        checks++;
        if (retired_count !== 16'd2) begin
            errors++;
            $display("FAIL notready_count got %0d exp 2", retired_count);
        end
    endtask

    task automatic test_branch();
        tick();
        head(1, 1, 6'd9, 5'd6, 32'h3333, 32'h100, DT_BRANCH, 1, 0);
        push(6'd9, 0, 5'd0, 32'h0);
        @(negedge clk);
        checks++;
        if (retire_ack !== 1'b1 || rf_wen !== 1'b0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL br_commit got ack %0b wen %0b fl %0b exp 1 0 0",
                     retire_ack, rf_wen, flush);
        end
        tick();
        head(1, 1, 6'd10, 5'd4, 32'h1234, 32'h0, DT_INT, 0, 0);
        push(6'd10, 1, 5'd4, 32'h1234);
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            checks++;
            if (flush !== 1'b1 || redirect_pc !== 32'h100 || retire_ack !== 1'b0) begin
                errors++;
                $display("FAIL br_flush N+%0d got fl %0b pc %h ack %0b exp 1 100 0",
                         i, flush, redirect_pc, retire_ack);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (flush !== 1'b0 || retire_ack !== 1'b1) begin
            errors++;
            $display("FAIL br_after N+3 got fl %0b ack %0b exp 0 1", flush, retire_ack);
        end
        tick();
        head(1, 1, 6'd11, 5'd2, 32'h0, 32'h200, DT_BRANCH, 0, 0);
        push(6'd11, 0, 5'd0, 32'h0);
        @(negedge clk);
        tick();
        clear_head();
        @(negedge clk);
        checks++;
        if (flush !== 1'b0 || retired_count !== 16'd5) begin
            errors++;
            $display("FAIL br_not_taken got fl %0b cnt %0d exp 0 5", flush, retired_count);
        end
    endtask

    task automatic test_store();
        tick();
        head(1, 1, 6'd12, 5'd0, 32'h0, 32'h0, DT_STORE, 0, 32'hCAFE);
        @(negedge clk);
        checks++;
        if (retire_ack !== 1'b0 || st_req !== 1'b0) begin
            errors++;
            $display("FAIL st_N got ack %0b req %0b exp 0 0", retire_ack, st_req);
        end
        for (int i = 1; i <= 2; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if (st_req !== 1'b1 || st_data !== 32'hCAFE || retire_ack !== 1'b0) begin
                errors++;
                $display("FAIL st_wait N+%0d got req %0b d %h ack %0b exp 1 cafe 0",
                         i, st_req, st_data, retire_ack);
            end
        end
        tick();
        st_ack = 1'b1;
        push(6'd12, 0, 5'd0, 32'h0);
        @(negedge clk);
        checks++;
        if (retire_ack !== 1'b1 || tag_free_en !== 1'b1 || tag_free !== 6'd12 ||
            rf_wen !== 1'b0) begin
            errors++;
            $display("FAIL st_ack N+3 got ack %0b fe %0b tag %0d wen %0b exp 1 1 12 0",
                     retire_ack, tag_free_en, tag_free, rf_wen);
        end
        tick();
        st_ack = 1'b0;
        clear_head();
        @(negedge clk);
        checks++;
        if (st_req !== 1'b0) begin
            errors++;
            $display("FAIL st_req_drop N+4 got %0b exp 0", st_req);
        end
        tick();
        st_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (retire_ack !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack got ack %0b exp 0", retire_ack);
        end
        tick();
        st_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (st_req !== 1'b0 || retired_count !== 16'd6) begin
            errors++;
            $display("FAIL stray_after got req %0b cnt %0d exp 0 6", st_req, retired_count);
        end
    endtask

    task automatic test_watchdog();
        tick();
        head(1, 1, 6'd20, 5'd0, 32'h0, 32'h0, DT_STORE, 0, 32'h55);
        for (int i = 1; i <= 4; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if (st_timeout !== 1'b0 || st_req !== 1'b1) begin
                errors++;
                $display("FAIL wd_early ST_WAIT %0d got to %0b req %0b exp 0 1",
                         i, st_timeout, st_req);
            end
        end
        for (int i = 5; i <= 7; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if (st_timeout !== 1'b1 || st_req !== 1'b1) begin
                errors++;
                $display("FAIL wd_set ST_WAIT %0d got to %0b req %0b exp 1 1",
                         i, st_timeout, st_req);
            end
        end
        tick();
        st_ack = 1'b1;
        push(6'd20, 0, 5'd0, 32'h0);
        @(negedge clk);
        checks++;
        if (retire_ack !== 1'b1) begin
            errors++;
            $display("FAIL wd_late_ack got %0b exp 1", retire_ack);
        end
        tick();
        st_ack = 1'b0;
        clear_head();
        @(negedge clk);
        checks++;
        if (st_timeout !== 1'b1 || st_req !== 1'b0) begin
            errors++;
            $display("FAIL wd_sticky got to %0b req %0b exp 1 0", st_timeout, st_req);
        end
    endtask

    task automatic test_reset_mid_store();
        tick();
        head(1, 1, 6'd30, 5'd0, 32'h0, 32'h0, DT_STORE, 0, 32'hBEEF);
        tick();
        @(negedge clk);
        checks++;
        if (st_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre got req %0b exp 1", st_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (st_req !== 1'b0 || retire_ack !== 1'b0 || st_timeout !== 1'b0 ||
            retired_count !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid got req %0b ack %0b to %0b cnt %0d exp 0 0 0 0",
                     st_req, retire_ack, st_timeout, retired_count);
        end
        clear_head();
        tick();
        tick();
        rst_n = 1'b1;
        head(1, 1, 6'd31, 5'd9, 32'h77, 32'h0, DT_LOAD, 0, 0);
        push(6'd31, 1, 5'd9, 32'h77);
        @(negedge clk);
        checks++;
        if (retire_ack !== 1'b1 || st_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle got ack %0b req %0b exp 1 0", retire_ack, st_req);
        end
        tick();
        clear_head();
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        sb_en = 1'b0;
        head(1, 1, 6'd1, 5'd1, 32'h1, 32'h0, DT_DIV, 0, 0);
        repeat (65535) @(posedge clk);
        #1;
        checks++;
        if (retired_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_max got %h exp ffff", retired_count);
        end
        @(posedge clk);
        #1;
        clear_head();
        checks++;
        if (retired_count !== 16'h0) begin
            errors++;
            $display("FAIL wrap_zero got %h exp 0000", retired_count);
        end
        tick();
        checks++;
        if (retired_count !== 16'h0) begin
            errors++;
            $display("FAIL wrap_hold got %h exp 0000", retired_count);
        end
        sb_en = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sb_en  = 1'b1;
        test_reset();
        test_int_commit();
        test_x0_notready();
        test_branch();
        test_store();
        test_watchdog();
        test_reset_mid_store();
        test_wrap();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
